// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood fan/hurricane/self-clean mode controller with per-second countdowns.
module hood_mode_ctrl #(
  parameter int unsigned LVL3_SEC      = 60,
  parameter int unsigned EXIT_SEC      = 60,
  parameter int unsigned CLEAN_MAX_SEC = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       power_key,
  input  logic       menu_key,
  input  logic       lvl1_req,
  input  logic       lvl2_req,
  input  logic       lvl3_req,
  input  logic       clean_req,
  input  logic       clean_done,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] countdown,
  output logic       clean_start,
  output logic       clean_abort,
  output logic       lvl3_used,
  output logic       clean_fault
);
  typedef enum logic [2:0] {OFF, STANDBY, LVL1, LVL2, LVL3, EXIT_WAIT, CLEAN} state_t;
  state_t state, nxt;
  logic [7:0] nxt_cd, dec;
  logic nxt_start, nxt_abort, nxt_used, nxt_fault;
  logic pk, mk, cr, l3, l2, l1;
  assign mode = state;
  assign dec = (countdown != 8'd0) ? countdown - 8'd1 : 8'd0;
  // Only the highest-priority key of a cycle acts; the rest are dropped.
  assign pk = power_key;
  assign mk = !pk && menu_key;
  assign cr = !pk && !menu_key && clean_req;
  assign l3 = !pk && !menu_key && !clean_req && lvl3_req;
  assign l2 = !pk && !menu_key && !clean_req && !lvl3_req && lvl2_req;
  assign l1 = !pk && !menu_key && !clean_req && !lvl3_req && !lvl2_req && lvl1_req;
  function automatic logic [1:0] fan_of(input state_t s);
    return s == LVL1 ? 2'd1 : (s == LVL2 || s == EXIT_WAIT) ? 2'd2 : s == LVL3 ? 2'd3 : 2'd0;
  endfunction
  always_comb begin
    nxt = state;
    nxt_cd = countdown;
    nxt_start = 1'b0;
    nxt_abort = 1'b0;
    nxt_used = lvl3_used;
    nxt_fault = clean_fault;
    case (state)
      OFF: nxt = pk ? STANDBY : OFF;
      STANDBY:
        if (pk) nxt = OFF;
        else if (cr) begin
          nxt = CLEAN;
          nxt_start = 1'b1;
          nxt_fault = 1'b0;
          nxt_cd = 8'(CLEAN_MAX_SEC);
        end else if (l3 && !lvl3_used) begin
          nxt = LVL3;
          nxt_used = 1'b1;
          nxt_cd = 8'(LVL3_SEC);
        end else nxt = l2 ? LVL2 : l1 ? LVL1 : STANDBY;
      LVL1, LVL2: nxt = pk ? OFF : mk ? STANDBY : l2 ? LVL2 : l1 ? LVL1 : state;
      LVL3:
        if (pk) nxt = OFF;
        else if (mk) begin
          nxt = EXIT_WAIT;
          nxt_cd = 8'(EXIT_SEC);
        end else if (tick_1s) begin
          nxt_cd = dec;
          nxt = dec == 8'd0 ? LVL2 : LVL3;
        end
      EXIT_WAIT:
        if (pk) nxt = OFF;
        else if (tick_1s) begin
          nxt_cd = dec;
          nxt = dec == 8'd0 ? STANDBY : EXIT_WAIT;
        end
      CLEAN:
        if (pk) begin
          nxt = OFF;
          nxt_abort = 1'b1;
        end else if (clean_done) nxt = STANDBY;
        else if (tick_1s) begin
          nxt_cd = dec;
          nxt = dec == 8'd0 ? STANDBY : CLEAN;
          nxt_fault = dec == 8'd0;
        end
      default: nxt = OFF;
    endcase
    if (nxt == OFF) nxt_used = 1'b0;
    if (nxt == OFF || nxt == STANDBY || nxt == LVL1 || nxt == LVL2) nxt_cd = 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      fan_level <= 2'd0;
      countdown <= 8'd0;
      clean_start <= 1'b0;
      clean_abort <= 1'b0;
      lvl3_used <= 1'b0;
      clean_fault <= 1'b0;
    end else begin
      state <= nxt;
      fan_level <= fan_of(nxt);
      countdown <= nxt_cd;
      clean_start <= nxt_start;
      clean_abort <= nxt_abort;
      lvl3_used <= nxt_used;
      clean_fault <= nxt_fault;
    end
  end
endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: scoreboard bench comparing hood_mode_ctrl against a behavioural model.
module tb_hood_mode_ctrl;
  localparam int L3S = 60, EXS = 60, CMS = 200;
  logic clk = 1'b0, rst = 1'b0, tick_1s = 1'b0, power_key = 1'b0, menu_key = 1'b0;
  logic lvl1_req = 1'b0, lvl2_req = 1'b0, lvl3_req = 1'b0, clean_req = 1'b0, clean_done = 1'b0;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] countdown;
  logic clean_start, clean_abort, lvl3_used, clean_fault;
  hood_mode_ctrl #(.LVL3_SEC(L3S), .EXIT_SEC(EXS), .CLEAN_MAX_SEC(CMS)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .power_key(power_key), .menu_key(menu_key),
    .lvl1_req(lvl1_req), .lvl2_req(lvl2_req), .lvl3_req(lvl3_req), .clean_req(clean_req),
    .clean_done(clean_done), .mode(mode), .fan_level(fan_level), .countdown(countdown),
    .clean_start(clean_start), .clean_abort(clean_abort), .lvl3_used(lvl3_used),
    .clean_fault(clean_fault)
  );
  always #5 clk = ~clk;
  typedef struct {int mode; int fan; int cd; int start; int abort; int used; int fault;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int m_mode = 0, m_cd = 0, m_used = 0, m_fault = 0, m_start = 0, m_abort = 0;
  int fan_tab[7] = '{0, 0, 1, 2, 3, 2, 0};
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  // Reference: modes 0 OFF,1 STANDBY,2 LVL1,3 LVL2,4 LVL3,5 EXIT_WAIT,6 CLEAN.
  task automatic model(input bit r, pk, mk, cr, l3, l2, l1, tk, dn);
    string key;
    m_start = 0;
    m_abort = 0;
    if (r) begin
      m_mode = 0; m_cd = 0; m_used = 0; m_fault = 0;
      return;
    end
    key = pk ? "pwr" : mk ? "menu" : cr ? "clean" : l3 ? "l3" : l2 ? "l2" : l1 ? "l1" : "";
    if (m_mode == 0) begin
      if (key == "pwr") m_mode = 1;
    end else if (key == "pwr") begin
      m_abort = (m_mode == 6) ? 1 : 0;
      m_mode = 0;
      m_used = 0;
    end else if (m_mode == 1) begin
      if (key == "clean") begin m_mode = 6; m_start = 1; m_fault = 0; m_cd = CMS; end
      else if (key == "l3" && m_used == 0) begin m_mode = 4; m_cd = L3S; m_used = 1; end
      else if (key == "l2") m_mode = 3;
      else if (key == "l1") m_mode = 2;
    end else if (m_mode == 2 || m_mode == 3) begin
      if (key == "menu") m_mode = 1;
      else if (key == "l2") m_mode = 3;
      else if (key == "l1") m_mode = 2;
    end else if (m_mode == 4) begin
      if (key == "menu") begin m_mode = 5; m_cd = EXS; end
      else if (tk) begin m_cd--; if (m_cd == 0) m_mode = 3; end
    end else if (m_mode == 5) begin
      if (tk) begin m_cd--; if (m_cd == 0) m_mode = 1; end
    end else if (m_mode == 6) begin
      if (dn) m_mode = 1;
      else if (tk) begin m_cd--; if (m_cd == 0) begin m_mode = 1; m_fault = 1; end end
    end
    if (m_mode <= 3) m_cd = 0;
  endtask
  task automatic step(input bit r, pk, mk, cr, l3, l2, l1, tk, dn);
    @(negedge clk);
    rst = r; power_key = pk; menu_key = mk; clean_req = cr; lvl3_req = l3;
    lvl2_req = l2; lvl1_req = l1; tick_1s = tk; clean_done = dn;
    model(r, pk, mk, cr, l3, l2, l1, tk, dn);
    q.push_back('{m_mode, fan_tab[m_mode], m_cd, m_start, m_abort, m_used, m_fault});
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      if (i % 7 == 3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("mode", int'(mode), e.mode);
        chk("fan_level", int'(fan_level), e.fan);
        chk("countdown", int'(countdown), e.cd);
        chk("clean_start", int'(clean_start), e.start);
        chk("clean_abort", int'(clean_abort), e.abort);
        chk("lvl3_used", int'(lvl3_used), e.used);
        chk("clean_fault", int'(clean_fault), e.fault);
      end
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1, 0);
    ticks(L3S);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    ticks(5);
    step(0, 0, 1, 0, 0, 0, 0, 1, 0);
    ticks(EXS);
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    ticks(10);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    ticks(CMS);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    ticks(CMS - 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    ticks(30);
    step(1, 0, 1, 1, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20000; i++)
      step($urandom_range(0, 999) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 Parameters SHALL be LVL3_SEC default 60 (hurricane run time, seconds), EXIT_SEC default 60 (hurricane-exit run-down, seconds), CLEAN_MAX_SEC default 200 (self-clean watchdog, seconds); each 1..255.
REQ-002 Ports SHALL be, in order: clk in 1 system clock; rst in 1 reset; tick_1s in 1 one-cycle pulse per second.
REQ-003 Ports SHALL continue: power_key in 1 pulse; menu_key in 1 pulse; lvl1_req, lvl2_req, lvl3_req in 1 each pulse; clean_req in 1 pulse; clean_done in 1 pulse from self-clean unit.
REQ-004 Outputs SHALL be: mode out 3 state code; fan_level out 2; countdown out 8 seconds remaining; clean_start out 1 pulse; clean_abort out 1 pulse; lvl3_used out 1; clean_fault out 1.
REQ-005 One clock; reset is synchronous and active-high (clk, rst).

Function
REQ-006 States and mode codes SHALL be OFF=0, STANDBY=1, LVL1=2, LVL2=3, LVL3=4, EXIT_WAIT=5, CLEAN=6; codes 7 map to OFF next cycle.
REQ-007 All outputs SHALL be registered; a state change takes effect on the clk edge that samples the causing input.
REQ-008 Simultaneous inputs SHALL resolve by priority: power_key > menu_key > clean_req > lvl3_req > lvl2_req > lvl1_req; lower-priority inputs that cycle are dropped.
REQ-009 OFF: power_key -> STANDBY; all other inputs ignored.
REQ-010 Any non-OFF state: power_key -> OFF; if leaving CLEAN, clean_abort SHALL pulse for exactly one cycle.
REQ-011 STANDBY: clean_req -> CLEAN; lvl3_req with lvl3_used=0 -> LVL3; lvl3_req with lvl3_used=1 ignored; lvl2_req -> LVL2; lvl1_req -> LVL1.
REQ-012 LVL1/LVL2: menu_key -> STANDBY; lvl1_req/lvl2_req switch between LVL1 and LVL2 directly; lvl3_req and clean_req ignored.
REQ-013 LVL3 entry SHALL load countdown=LVL3_SEC and set lvl3_used=1; countdown decrements on each tick_1s; the tick that makes countdown 0 moves to LVL2 that same edge.
REQ-014 LVL3: menu_key -> EXIT_WAIT with countdown loaded EXIT_SEC; lvl1/lvl2/lvl3/clean requests ignored.
REQ-015 EXIT_WAIT: countdown decrements on tick_1s; the tick making it 0 -> STANDBY; lvl/clean/menu requests ignored.
REQ-016 CLEAN entry SHALL pulse clean_start one cycle, clear clean_fault, load countdown=CLEAN_MAX_SEC; clean_done -> STANDBY; countdown reaching 0 before clean_done -> STANDBY with clean_fault=1 (sticky until next CLEAN entry or rst).
REQ-017 clean_done SHALL be ignored outside CLEAN; clean_done and the final tick in the same cycle count as success (no fault).
REQ-018 countdown SHALL be 0 in OFF, STANDBY, LVL1, LVL2; never underflows.
REQ-019 fan_level SHALL be 0 in OFF/STANDBY/CLEAN, 1 in LVL1, 2 in LVL2 and EXIT_WAIT, 3 in LVL3.
REQ-020 lvl3_used SHALL clear only on entry to OFF or rst.
REQ-021 tick_1s only affects countdown in LVL3, EXIT_WAIT, CLEAN; a tick on the entry cycle SHALL NOT decrement the freshly loaded value.

Reset
REQ-022 On rst at any clk edge, including mid-CLEAN or mid-LVL3: mode=OFF, fan_level=0, countdown=0, clean_start=0, clean_abort=0, lvl3_used=0, clean_fault=0; rst has priority over all inputs and generates no clean_abort.

Verification
REQ-023 rst; power_key; lvl3_req; 60 ticks -> mode 4, countdown 60..1, then mode 3, fan_level 2, lvl3_used=1; menu_key, lvl3_req -> mode 1 then stays 1.
REQ-024 STANDBY, lvl3_req, 5 ticks, menu_key -> mode 5, countdown 60, fan_level 2; 60 ticks -> mode 1, countdown 0.
REQ-025 STANDBY, clean_req -> mode 6, clean_start high one cycle, countdown 200; 10 ticks, clean_done -> mode 1, clean_fault 0.
REQ-026 CLEAN with no clean_done for 200 ticks -> mode 1, clean_fault 1; power_key in CLEAN -> mode 0, clean_abort one cycle.
REQ-027 STANDBY, power_key+clean_req+lvl1_req same cycle -> mode 0, no clean_start; power_key again -> lvl3_req accepted (lvl3_used cleared).
REQ-028 rst asserted mid-LVL3 (countdown 30) -> next edge all outputs at reset values.
